uart_transmitter: RTL
=====================

# uart_transmitter

Serial transmit stage of the UART: accepts a byte from the processor bus, frames it as 8N1 (one start bit, eight data bits LSB first, one stop bit) and drives it onto the serial output. Bit timing comes from the same 16x baud-rate enable that drives the receive side, so a frame from this block is sampled correctly by the team's receiver on the far end. Double-buffered (holding register plus shift register), so back-to-back bytes go out with no idle gap.

## Interface
- No parameters.
  - Frame format fixed at 8N1.
  - Oversampling fixed at 16.
- clk  input  1  system clock.
  - One clock; all logic on posedge clk.
- rst  input  1  reset.
  - Synchronous, active-high.
- t_enable  input  1  16x baud-rate enable from the baud generator.
  - One-clock pulse, 16 pulses per bit time.
- tx_enable  input  1  processor write strobe.
  - High for one clock when the processor writes a byte.
- data  input  8  byte from the processor bus.
  - Sampled when tx_enable is high.
- txd  output  1  serial output, registered.
  - Idles high.
- tbr  output  1  transmit buffer ready.
  - High when the holding register is empty and a write will be accepted.

## Operation
- Holding register (hold, hold_full):
  - Write accepted when tx_enable=1 and tbr=1: hold<=data, hold_full<=1.
  - Write with tbr=0 is a protocol violation: ignored, hold unchanged.
  - tbr is the registered inverse of hold_full.
- Transmit FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1.
    - If hold_full: shift<=hold, hold_full<=0, bitcnt<=0, tickcnt<=0, txd<=0, go to START.
  - START: txd=0.
    - Go to DATA after 16 t_enable pulses, driving txd<=shift[0].
  - DATA: txd=shift[0].
    - After every 16th pulse: shift right by one, bitcnt+1.
    - After 8 bits: txd<=1, go to STOP.
  - STOP: txd=1 for 16 pulses.
    - At the end, if hold_full: load shift and go directly to START, with the same actions as in IDLE; no idle bit.
    - Otherwise go to IDLE.
- Counters:
  - tickcnt is 4 bits and wraps 15→0 on the bit-advancing pulse.
  - bitcnt is 4 bits and only reaches 8 when leaving DATA.
  - t_enable is ignored in IDLE.
- Simultaneous events:
  - A write cannot coincide with a hold→shift transfer, because a transfer requires tbr=0.
  - A write arriving in the same cycle that tbr rises is not accepted; tbr is evaluated as registered.
- Reset: txd=1, tbr=1, hold_full=0, hold=0, shift=0, state=IDLE, tickcnt=0, bitcnt=0.
  - Reset mid-frame aborts the frame. txd returns high on the next edge and the buffered byte is discarded.
  - Reset has priority over tx_enable in the same cycle.

## Timing
- Write at edge n (tx_enable=1, tbr=1):
  - tbr=0 and hold_full=1 from n+1.
- With the FSM in IDLE, the transfer happens at edge n+2:
  - txd=0 from n+2.
  - tbr=1 again from n+2, so a second byte can be queued during the first frame.
- Each bit lasts exactly 16 t_enable pulses, counted from the bit's first cycle.
  - A frame is 160 pulses.
  - Latency from write to txd falling is 2 clocks, independent of t_enable phase.
- Back-to-back: the next start bit begins on the clock after the 16th stop-bit pulse.
- The txd transition occurs one clock after the t_enable pulse that completes the previous bit.

## Structure
- Shared UART package holds:
  - state encoding (IDLE, START, DATA, STOP)
  - OVERSAMPLE=16
  - DATA_BITS=8
  - IDLE_LEVEL=1'b1
- These constants are shared with the receiver.
- Single module, no sub-module.
  - The tick counter and bit counter are small enough to inline.
  - The baud generator stays a separate existing block feeding t_enable.

## Test plan
- Reset, then idle for 100 clocks with t_enable pulsing -> txd=1 and tbr=1 throughout.
- Write 0xA5 with t_enable every 4 clocks -> tbr low 1 clock later and high 2 clocks after the write; txd falls 2 clocks after the write; txd carries 0,1,0,1,0,0,1,0,1,1 with each level held 64 clocks; then txd idles high.
- Write 0x3C, then 0xC3 while 0x3C is shifting -> 0xC3 is accepted because tbr=1; its start bit follows the 0x3C stop bit with zero idle gap; tbr stays low until 0xC3 transfers.
- Write 0x11 while tbr=0 (buffer full) -> the write is ignored; the frames carry only the two earlier bytes.
- Assert rst during data bit 4 of 0xFF -> txd=1 and tbr=1 on the next edge; no further frame is sent; a later write of 0x00 transmits a clean frame.
- Loopback txd into the team's receiver at the same baud enable; send 0x00, 0xFF and 0x5A -> the receiver presents identical bytes with its data-ready flag set.

Source files
------------

// File: rtl/uart_pkg.sv
// Constants shared by the UART transmit and receive stages: frame geometry,
// oversampling ratio, line idle level and the transmit/receive FSM encoding.
package uart_pkg;

  localparam int   OVERSAMPLE = 16;
  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_START = 2'd1;
  localparam logic [STATE_W-1:0] ST_DATA  = 2'd2;
  localparam logic [STATE_W-1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter, double-buffered (holding register + shift register),
// bit timing from the shared 16x baud enable.
module uart_transmitter
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       t_enable,
  input  logic       tx_enable,
  input  logic [7:0] data,
  output logic       txd,
  output logic       tbr
);

  logic [STATE_W-1:0]   state;
  logic [DATA_BITS-1:0] hold;
  logic [DATA_BITS-1:0] shift;
  logic                 hold_full;
  logic [3:0]           tickcnt;
  logic [3:0]           bitcnt;
  logic                 accept;
  logic                 bit_done;
  logic                 load;

  // tbr is the registered flag, so a write in the cycle tbr rises is not taken.
  assign accept   = tx_enable && tbr;
  assign bit_done = t_enable && (tickcnt == 4'(OVERSAMPLE - 1));

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    load = 1'b0;
    case (state)
      ST_IDLE: load = hold_full;
      ST_STOP: load = bit_done && hold_full;
      default: load = 1'b0;
    endcase
  end

  // Holding register; a write and a transfer are mutually exclusive because
  // a transfer needs hold_full=1, which forces tbr=0.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: hold is a plain register, not a memory array, so it is reset too.
      hold      <= '0;
      hold_full <= 1'b0;
      tbr       <= 1'b1;
    end else if (accept) begin
      hold      <= data;
      hold_full <= 1'b1;
      tbr       <= 1'b0;
    end else if (load) begin
      hold_full <= 1'b0;
      tbr       <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      shift   <= '0;
      tickcnt <= '0;
      bitcnt  <= '0;
      txd     <= IDLE_LEVEL;
    end else if (load) begin
      // Same transfer from IDLE and from the end of STOP: no idle bit between frames.
      shift   <= hold;
      tickcnt <= '0;
      bitcnt  <= '0;
      txd     <= ~IDLE_LEVEL;
      state   <= ST_START;
    end else if (state != ST_IDLE && t_enable) begin
      tickcnt <= tickcnt + 4'd1;
      if (bit_done) begin
        case (state)
          ST_START: begin
            txd   <= shift[0];
            state <= ST_DATA;
          end
          ST_DATA: begin
            shift  <= shift >> 1;
            bitcnt <= bitcnt + 4'd1;
            if (bitcnt == 4'(DATA_BITS - 1)) begin
              txd   <= IDLE_LEVEL;
              state <= ST_STOP;
            end else begin
              txd <= shift[1];
            end
          end
          ST_STOP: begin
            txd   <= IDLE_LEVEL;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
